muladd_job_ctrl: RTL
====================

Name: muladd_job_ctrl

Overview:
- Job controller that sequences the HLS muladd kernel (ap_ctrl_hs control, ap_memory operand ports).
- Holds two ping-pong operand banks (A and B vectors per bank), loaded by a host write port.
- Queues dot-product jobs per bank, drives the kernel start/done handshake and serves the kernel's a/b memory reads from the running bank.
- Returns each 32-bit ap_return with its job tag over a valid/ready result port; also provides sticky error flags and a latency counter.

Parameters:
- DATA_W, 16, operand element width.
- DEPTH, 16, elements per vector.
- ADDR_W, 4, kernel/host address width; must equal clog2(DEPTH).
- RES_W, 32, kernel return width.
- TAG_W, 4, job tag width.
- TIMEOUT, 1024, cycles in WAIT before err_timeout is set.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host operand write strobe.
- wr_bank  in  1  target bank (0/1).
- wr_sel  in  1  0 = A vector, 1 = B vector.
- wr_addr  in  ADDR_W  element index.
- wr_data  in  DATA_W  element value.
- job_valid  in  1  job request.
- job_ready  out  1  job accepted when job_valid && job_ready.
- job_bank  in  1  bank the job operates on.
- job_tag  in  TAG_W  opaque job id.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  RES_W  captured ap_return.
- res_tag  out  TAG_W  tag of the result.
- bank_busy  out  2  per-bank: job queued or running.
- err_wr_busy  out  1  sticky: write to busy bank dropped.
- err_timeout  out  1  sticky: WAIT exceeded TIMEOUT.
- err_clr  in  1  clears both sticky flags.
- last_lat  out  16  cycles from start to ap_done of the last job (saturating).
- k_ap_start  out  1  kernel start.
- k_ap_done  in  1  kernel done.
- k_ap_idle  in  1  kernel idle (status only).
- k_ap_ready  in  1  kernel ready.
- k_ap_return  in  RES_W  kernel result.
- k_a_address0  in  ADDR_W  kernel A read address.
- k_a_ce0  in  1  kernel A read enable.
- k_a_q0  out  DATA_W  A read data.
- k_b_address0  in  ADDR_W  kernel B read address.
- k_b_ce0  in  1  kernel B read enable.
- k_b_q0  out  DATA_W  B read data.

Behaviour:
- Reset (async assert):
  - Outputs: job_ready=0, res_valid=0, res_data=0, res_tag=0, bank_busy=0, err flags=0, last_lat=0, k_ap_start=0, k_*_q0=0.
  - FSM=IDLE, queue emptied.
  - Operand banks are not cleared.
  - Reset mid-job abandons the job; the kernel shares ap_rst.
- job_ready is a registered function: !bank_busy[job_bank] (combinational from registered busy).
- Accept sets bank_busy[job_bank] and pushes (bank, tag) into a 2-entry FIFO. Service order is acceptance order.
- Host writes:
  - Write to a non-busy bank updates the element on the next edge.
  - Write to a busy bank is dropped and sets err_wr_busy.
  - err_clr has priority over a same-cycle set.
- FSM:
  - IDLE: FIFO non-empty -> START (pop, latch run_bank/run_tag, k_ap_start<=1, latency counter<=1).
  - START: k_ap_start held high until k_ap_ready is sampled high; k_ap_start is low the following cycle. Then -> WAIT, or -> CAPTURE if k_ap_done is also high that cycle.
  - WAIT: on k_ap_done, capture k_ap_return into res_data and run_tag into res_tag; set res_valid; clear bank_busy[run_bank]; latch last_lat; -> RESULT.
  - RESULT: res_valid held, res_data and res_tag stable, until res_ready. On handshake: -> START if FIFO non-empty, else -> IDLE. No new kernel start while a result is pending.
- Timeout: counter runs in START/WAIT. Reaching TIMEOUT sets err_timeout; the FSM keeps waiting (no abort).
- Kernel memory reads: 1-cycle latency. If k_a_ce0 is high in cycle t, k_a_q0 = A[run_bank][k_a_address0] in cycle t+1; otherwise k_a_q0 holds its value. B port is identical. Reads outside START/WAIT return 0.
- Bank freed and accept in the same cycle: the accept sees the old busy value and stalls one cycle. This is deterministic.
- last_lat saturates at 16'hFFFF.

Decomposition:
- Package muladd_ctrl_pkg: FSM state enum (IDLE, START, WAIT, RESULT); job-entry struct {bank, tag}; width constants.
- One natural sub-module: muladd_opbank, the dual-bank register file with host write port and two 1-cycle kernel read ports. The FSM and FIFO stay in the top module.

Test Plan:
- Load bank0 with A[i]=i, B[i]=2i; job bank0 tag 3 -> res_data=2480, res_tag=3; bank_busy returns to 0; last_lat matches the kernel model.
- Load bank1 with A=B=1 while the bank0 job runs; queue jobs tag1 (bank0) and tag2 (bank1) -> results 2480 then 16, in that order. A third job to bank0 stalls until the first ap_done.
- Hold res_ready=0 for 10 cycles after res_valid -> res_data and res_tag stable, k_ap_start stays 0 although the FIFO is non-empty. Releasing res_ready starts the next job the following cycle.
- Write to bank0 while its job runs -> err_wr_busy=1 and the result is still 2480. err_clr -> flag=0.
- TIMEOUT=64, kernel model delays ap_done 100 cycles -> err_timeout rises at cycle 64; the result is still delivered correctly.
- Assert ap_rst in WAIT -> all outputs at reset values immediately; after release, a fresh job completes normally.

Source files
------------

// File: rtl/muladd_ctrl_pkg.sv
// rtl/muladd_ctrl_pkg.sv - shared types and constants for the muladd job controller
package muladd_ctrl_pkg;

  localparam int JOB_TAG_W = 4;
  localparam int LAT_W     = 16;
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } state_t;

  typedef struct packed {
    logic                 bank;
    logic [JOB_TAG_W-1:0] tag;
  } job_t;

endpackage

// File: rtl/muladd_opbank.sv
// rtl/muladd_opbank.sv - dual-bank A/B operand store with host write and 1-cycle kernel reads
module muladd_opbank
  import muladd_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_ce,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_ce,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem_a [2][DEPTH];
  logic [DATA_W-1:0] mem_b [2][DEPTH];

  // Operand storage survives reset so a host can preload before releasing it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) mem_b[wr_bank][wr_addr] <= wr_data;
      else        mem_a[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Kernel read ports: data one cycle after ce, zero when no job is running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_ce) a_q <= rd_en ? mem_a[rd_bank][a_addr] : '0;
      if (b_ce) b_q <= rd_en ? mem_b[rd_bank][b_addr] : '0;
    end
  end

endmodule

// File: rtl/muladd_job_ctrl.sv
// rtl/muladd_job_ctrl.sv - job queue, ap_ctrl_hs sequencer and result port for the muladd kernel
module muladd_job_ctrl
  import muladd_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int RES_W   = 32,
  parameter int TAG_W   = JOB_TAG_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_bank,
  input  logic [TAG_W-1:0]  job_tag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic [1:0]        bank_busy,
  output logic              err_wr_busy,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [15:0]       last_lat,
  output logic              k_ap_start,
  input  logic              k_ap_done,
  input  logic              k_ap_idle,
  input  logic              k_ap_ready,
  input  logic [RES_W-1:0]  k_ap_return,
  input  logic [ADDR_W-1:0] k_a_address0,
  input  logic              k_a_ce0,
  output logic [DATA_W-1:0] k_a_q0,
  input  logic [ADDR_W-1:0] k_b_address0,
  input  logic              k_b_ce0,
  output logic [DATA_W-1:0] k_b_q0
);

  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

  state_t           state, state_next;
  job_t             fifo_mem [2];
  logic             fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]       fifo_cnt;
  job_t             head;
  logic             live;
  logic             run_bank;
  logic [TAG_W-1:0] run_tag;
  logic [LAT_W-1:0] lat_cnt;
  logic             push, pop, capture, in_run;
  logic [1:0]       busy_set, busy_clr;
  logic             unused_idle;

  // idle is informational only; the handshake uses ready/done
  assign unused_idle = k_ap_idle;

  // live keeps job_ready low during reset and the first cycle after it
  assign job_ready  = live && !bank_busy[job_bank];
  assign push       = job_valid && job_ready;
  assign head       = fifo_mem[fifo_rd_ptr];
  assign in_run     = (state == ST_START) || (state == ST_WAIT);
  assign k_ap_start = (state == ST_START);
  assign busy_set   = push    ? (2'b01 << job_bank) : 2'b00;
  assign busy_clr   = capture ? (2'b01 << run_bank) : 2'b00;

  // FSM state register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state plus pop/capture strobes; a pending result blocks new starts
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fifo_cnt != 2'd0) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (k_ap_ready) begin
          if (k_ap_done) begin
            capture    = 1'b1;
            state_next = ST_RESULT;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (k_ap_done) begin
          capture    = 1'b1;
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          if (fifo_cnt != 2'd0) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Two-entry job FIFO; busy bits guarantee it never overflows
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= job_t'{bank: job_bank, tag: job_tag};
        fifo_wr_ptr           <= !fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= !fifo_rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Job bookkeeping: busy bits, running job, latency counter, result capture
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      live      <= 1'b0;
      bank_busy <= 2'b00;
      run_bank  <= 1'b0;
      run_tag   <= '0;
      lat_cnt   <= '0;
      last_lat  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      live      <= 1'b1;
      bank_busy <= (bank_busy & ~busy_clr) | busy_set;
      if (pop) begin
        run_bank <= head.bank;
        run_tag  <= head.tag;
        lat_cnt  <= LAT_W'(1);
      end else if (in_run && lat_cnt != LAT_MAX) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= k_ap_return;
        res_tag   <= run_tag;
        last_lat  <= lat_cnt;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      err_wr_busy <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (err_clr)                         err_wr_busy <= 1'b0;
      else if (wr_en && bank_busy[wr_bank]) err_wr_busy <= 1'b1;
      if (err_clr)                         err_timeout <= 1'b0;
      else if (in_run && lat_cnt >= TIMEOUT_L) err_timeout <= 1'b1;
    end
  end

  muladd_opbank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_opbank (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .wr_en   (wr_en && !bank_busy[wr_bank]),
    .wr_bank (wr_bank),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (in_run),
    .rd_bank (run_bank),
    .a_addr  (k_a_address0),
    .a_ce    (k_a_ce0),
    .a_q     (k_a_q0),
    .b_addr  (k_b_address0),
    .b_ce    (k_b_ce0),
    .b_q     (k_b_q0)
  );

endmodule
